// File: rtl/trigger_engine_if.sv
// trigger_engine_if: control, configuration, sample and status bundle of the trigger engine.
// master: capture controller (drives Arm..Dig, observes Start/State/Trig_Lat); slave: engine.
interface trigger_engine_if #(
   parameter int N_ACH = 2,
   parameter int DW    = 8,
   parameter int N_DCH = 2,
   parameter int CW    = 32
);
   logic                   Arm;
   logic                   Force;
   logic                   Sampled;
   logic [3:0]             Trig_Src;
   logic [2:0]             Trig_Type;
   logic [DW-1:0]          Vthreshold;
   logic [CW-1:0]          XTthreshold;
   logic [CW-1:0]          Holdoff;
   logic [N_ACH*DW-1:0]    Ana;
   logic [N_DCH-1:0]       Dig;
   logic                   Start;
   logic [1:0]             State;
   logic [CW-1:0]          Trig_Lat;

   modport master (
      output Arm, Force, Sampled, Trig_Src, Trig_Type,
      output Vthreshold, XTthreshold, Holdoff, Ana, Dig,
      input  Start, State, Trig_Lat
   );

   modport slave (
      input  Arm, Force, Sampled, Trig_Src, Trig_Type,
      input  Vthreshold, XTthreshold, Holdoff, Ana, Dig,
      output Start, State, Trig_Lat
   );
endinterface

// File: rtl/trigger_engine.sv
// trigger_engine: arm/pretrig/armed/trig sequencer with edge (hysteresis), level and
// pulse-width conditions over N_ACH analog and N_DCH digital channels, plus holdoff.
// Ports: Mclk clock; Reset sync active-high; bus (slave) carries Arm, Force, Sampled,
// Trig_Src, Trig_Type, Vthreshold, XTthreshold, Holdoff, Ana, Dig in and Start, State,
// Trig_Lat out. Samples are registered once, so a qualifying sample captured at edge n
// shows up as State=TRIG/Start=1 after edge n+1.
module trigger_engine #(
   parameter int N_ACH = 2,
   parameter int DW    = 8,
   parameter int N_DCH = 2,
   parameter int CW    = 32,
   parameter int HYST  = 12
) (
   input  logic                Mclk,
   input  logic                Reset,
   trigger_engine_if.slave     bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRETRIG = 2'd1,
      ARMED   = 2'd2,
      TRIG    = 2'd3
   } state_e;

   localparam logic [DW:0] HYST_W = (DW+1)'(HYST);
   localparam logic [DW:0] DMAX   = {1'b0, {DW{1'b1}}};

   state_e              state_q, state_d;
   logic                start_q, start_d;
   logic [CW-1:0]       lat_q, lat_d;
   logic [CW-1:0]       hcnt_q, hcnt_d;
   logic [CW-1:0]       pcnt_q, pcnt_d;
   logic                lo_q, lo_d;
   logic                hi_q, hi_d;
   logic                seen_q, seen_d;
   logic [N_ACH*DW-1:0] ana_q;
   logic [N_DCH-1:0]    dig_q;
   logic [N_DCH-1:0]    dprev_q;
   logic [N_ACH-1:0]    abit_q, abit_d;

   logic [DW:0]         vth_w, vsum, vh_w, vl_w;
   logic [DW-1:0]       x;
   logic                src_ana, src_dig, src_ok;
   logic                bit_c, bit_p, tr;
   logic                x_gt, x_lt;
   logic                pos_c, neg_c, lvl_l, lvl_h;
   logic [CW:0]         pw;
   logic                p_lt;
   logic                cond_c;

   // Saturated hysteresis band around the live threshold.
   always_comb begin
      vth_w = {1'b0, bus.Vthreshold};
      vsum  = vth_w + HYST_W;
      vh_w  = (vsum > DMAX) ? DMAX : vsum;
      vl_w  = (vth_w >= HYST_W) ? (vth_w - HYST_W) : '0;
   end

   // Digitised analog bits; an exact threshold hit keeps the previous bit.
   always_comb begin
      abit_d = abit_q;
      for (int k = 0; k < N_ACH; k++) begin
         if (ana_q[k*DW +: DW] > bus.Vthreshold) begin
            abit_d[k] = 1'b1;
         end else if (ana_q[k*DW +: DW] < bus.Vthreshold) begin
            abit_d[k] = 1'b0;
         end
      end
   end

   // Channel select: current/previous bit and raw analog value.
   always_comb begin
      x       = '0;
      src_ana = 1'b0;
      src_dig = 1'b0;
      bit_c   = 1'b0;
      bit_p   = 1'b0;
      for (int k = 0; k < N_ACH; k++) begin
         if (bus.Trig_Src == 4'(k)) begin
            src_ana = 1'b1;
            x       = ana_q[k*DW +: DW];
            bit_c   = abit_d[k];
            bit_p   = abit_q[k];
         end
      end
      for (int k = 0; k < N_DCH; k++) begin
         if (bus.Trig_Src == 4'(N_ACH + k)) begin
            src_dig = 1'b1;
            bit_c   = dig_q[k];
            bit_p   = dprev_q[k];
         end
      end
   end

   // Trigger condition on the registered sample.
   always_comb begin
      src_ok = src_ana | src_dig;
      x_gt   = x > bus.Vthreshold;
      x_lt   = x < bus.Vthreshold;
      tr     = bit_c ^ bit_p;
      pos_c  = src_ana ? (lo_q & x_gt) : (bit_c & ~bit_p);
      neg_c  = src_ana ? (hi_q & x_lt) : (~bit_c & bit_p);
      lvl_l  = src_ana ? x_lt : ~bit_c;
      lvl_h  = src_ana ? x_gt : bit_c;
      // Completed pulse is pcnt+1 cycles long; extra bit avoids wrap.
      pw     = {1'b0, pcnt_q} + (CW+1)'(1);
      p_lt   = pw < {1'b0, bus.XTthreshold};
      cond_c = 1'b0;
      case (bus.Trig_Type)
         3'd0: cond_c = neg_c;
         3'd1: cond_c = pos_c;
         3'd2: cond_c = lvl_l;
         3'd3: cond_c = lvl_h;
         3'd4: cond_c = tr & seen_q &  bit_c &  p_lt;
         3'd5: cond_c = tr & seen_q &  bit_c & ~p_lt;
         3'd6: cond_c = tr & seen_q & ~bit_c &  p_lt;
         3'd7: cond_c = tr & seen_q & ~bit_c & ~p_lt;
      endcase
      cond_c = cond_c & src_ok;
   end

   // Next state, counters and flags.
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      hcnt_d  = hcnt_q;
      pcnt_d  = pcnt_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      seen_d  = seen_q;
      unique case (state_q)
         IDLE: begin
            if (bus.Arm) begin
               state_d = PRETRIG;
               hcnt_d  = '0;
            end
         end
         PRETRIG: begin
            if (bus.Arm) begin
               hcnt_d = '0;
            end else if (bus.Force) begin
               state_d = TRIG;
            end else begin
               if (bus.Sampled && (hcnt_q >= bus.Holdoff)) begin
                  state_d = ARMED;
               end
               if (hcnt_q != '1) begin
                  hcnt_d = hcnt_q + CW'(1);
               end
            end
         end
         ARMED: begin
            if (bus.Arm) begin
               state_d = PRETRIG;
               hcnt_d  = '0;
            end else begin
               if (lat_q != '1) begin
                  lat_d = lat_q + CW'(1);
               end
               if (src_ana && ({1'b0, x} < vl_w)) begin
                  lo_d = 1'b1;
               end
               if (src_ana && ({1'b0, x} > vh_w)) begin
                  hi_d = 1'b1;
               end
               if (src_ok) begin
                  if (tr) begin
                     seen_d = 1'b1;
                     pcnt_d = '0;
                  end else if (pcnt_q != '1) begin
                     pcnt_d = pcnt_q + CW'(1);
                  end
               end
               if (cond_c || bus.Force) begin
                  state_d = TRIG;
               end
            end
         end
         TRIG: begin
            if (bus.Arm) begin
               state_d = PRETRIG;
               hcnt_d  = '0;
            end
         end
      endcase
      // Fresh history on every entry into ARMED.
      if ((state_d == ARMED) && (state_q != ARMED)) begin
         lo_d   = 1'b0;
         hi_d   = 1'b0;
         seen_d = 1'b0;
         pcnt_d = '0;
         lat_d  = '0;
      end
      start_d = (state_d == TRIG);
   end

   always_ff @(posedge Mclk) begin
      if (Reset) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         lat_q   <= '0;
         hcnt_q  <= '0;
         pcnt_q  <= '0;
         lo_q    <= 1'b0;
         hi_q    <= 1'b0;
         seen_q  <= 1'b0;
         ana_q   <= '0;
         dig_q   <= '0;
         dprev_q <= '0;
         abit_q  <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         lat_q   <= lat_d;
         hcnt_q  <= hcnt_d;
         pcnt_q  <= pcnt_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         seen_q  <= seen_d;
         ana_q   <= bus.Ana;
         dig_q   <= bus.Dig;
         dprev_q <= dig_q;
         abit_q  <= abit_d;
      end
   end

   assign bus.Start    = start_q;
   assign bus.State    = state_q;
   assign bus.Trig_Lat = lat_q;

endmodule

// File: tb/tb_trigger_engine.sv
// tb_trigger_engine: randomized and directed stimulus for trigger_engine with a
// history-based reference model feeding a scoreboard checked by a negedge monitor.
module tb_trigger_engine;
   localparam int N_ACH = 2;
   localparam int DW    = 8;
   localparam int N_DCH = 2;
   localparam int CW    = 32;
   localparam int HYST  = 12;

   typedef struct {
      logic [1:0]  st;
      logic        start;
      logic [31:0] lat;
   } exp_t;

   logic Mclk = 1'b0;
   logic Reset;
   always #5 Mclk = ~Mclk;

   trigger_engine_if #(
      .N_ACH(N_ACH), .DW(DW), .N_DCH(N_DCH), .CW(CW)
   ) bus ();

   trigger_engine #(
      .N_ACH(N_ACH), .DW(DW), .N_DCH(N_DCH), .CW(CW), .HYST(HYST)
   ) dut (
      .Mclk(Mclk),
      .Reset(Reset),
      .bus(bus.slave)
   );

   int vectors = 0;
   int miscompares = 0;
   exp_t sbq[$];
   exp_t me;

   int c_src = 0, c_type = 0, c_vth = 128, c_T = 1, c_hold = 0;

   int               m_st = 0;
   longint           m_lat = 0, m_hcnt = 0;
   int               r_ana[N_ACH];
   bit [N_DCH-1:0]   r_dig;
   bit [N_ACH-1:0]   m_abit;
   bit [N_DCH-1:0]   m_dprev;
   int               hist[$];
   bit               bits[$];

   // Condition judged from the sample stream seen since ARMED entry.
   function automatic bit cond_now(input bit cur, input bit prv, input int x);
      int vh, vl, n, j, w;
      bit lo, hi;
      vh = (c_vth + HYST > 255) ? 255 : c_vth + HYST;
      vl = (c_vth - HYST < 0) ? 0 : c_vth - HYST;
      lo = 0;
      hi = 0;
      foreach (hist[i]) begin
         if (hist[i] < vl) lo = 1;
         if (hist[i] > vh) hi = 1;
      end
      if (c_src >= N_ACH + N_DCH) return 0;
      if (c_type < 4) begin
         if (c_src < N_ACH) begin
            case (c_type)
               0: return hi && (x < c_vth);
               1: return lo && (x > c_vth);
               2: return x < c_vth;
               default: return x > c_vth;
            endcase
         end
         case (c_type)
            0: return prv && !cur;
            1: return !prv && cur;
            2: return !cur;
            default: return cur;
         endcase
      end
      if (cur == prv) return 0;
      n = bits.size();
      j = 0;
      for (int i = 1; i < n; i++) if (bits[i] != bits[i-1]) j = i;
      if (j == 0) return 0;
      w = n - j;
      case (c_type)
         4: return cur && (w < c_T);
         5: return cur && (w >= c_T);
         6: return !cur && (w < c_T);
         default: return !cur && (w >= c_T);
      endcase
   endfunction

   task automatic model_step(input bit rst, input bit arm, input bit frc, input bit smp,
                             input logic [N_ACH*DW-1:0] av, input logic [N_DCH-1:0] dv);
      int nx, x;
      bit cur, prv, fire;
      bit [N_ACH-1:0] nb;
      if (rst) begin
         m_st = 0; m_lat = 0; m_hcnt = 0;
         foreach (r_ana[k]) r_ana[k] = 0;
         r_dig = '0; m_abit = '0; m_dprev = '0;
         hist.delete(); bits.delete();
         return;
      end
      for (int k = 0; k < N_ACH; k++)
         nb[k] = (r_ana[k] > c_vth) ? 1'b1 : (r_ana[k] < c_vth) ? 1'b0 : m_abit[k];
      cur = 0; prv = 0; x = 0;
      if (c_src < N_ACH) begin
         x = r_ana[c_src]; cur = nb[c_src]; prv = m_abit[c_src];
      end else if (c_src < N_ACH + N_DCH) begin
         cur = r_dig[c_src-N_ACH]; prv = m_dprev[c_src-N_ACH];
      end
      nx = m_st;
      case (m_st)
         0: if (arm) begin nx = 1; m_hcnt = 0; end
         1: begin
            if (arm) m_hcnt = 0;
            else if (frc) nx = 3;
            else begin
               if (smp && m_hcnt >= c_hold) nx = 2;
               m_hcnt++;
            end
         end
         2: begin
            if (arm) begin nx = 1; m_hcnt = 0; end
            else begin
               m_lat++;
               fire = frc || cond_now(cur, prv, x);
               hist.push_back(x);
               bits.push_back(cur);
               if (fire) nx = 3;
            end
         end
         default: if (arm) begin nx = 1; m_hcnt = 0; end
      endcase
      if (nx == 2 && m_st != 2) begin
         hist.delete(); bits.delete();
         bits.push_back(cur);
         m_lat = 0;
      end
      m_abit = nb;
      m_dprev = r_dig;
      for (int k = 0; k < N_ACH; k++) r_ana[k] = int'(av[k*DW +: DW]);
      r_dig = dv;
      m_st = nx;
   endtask

   task automatic step(input bit rst, input bit arm, input bit frc, input bit smp,
                       input logic [N_ACH*DW-1:0] av, input logic [N_DCH-1:0] dv);
      exp_t e;
      Reset = rst;
      bus.Arm = arm; bus.Force = frc; bus.Sampled = smp;
      bus.Trig_Src = 4'(c_src); bus.Trig_Type = 3'(c_type);
      bus.Vthreshold = 8'(c_vth); bus.XTthreshold = 32'(c_T); bus.Holdoff = 32'(c_hold);
      bus.Ana = av; bus.Dig = dv;
      model_step(rst, arm, frc, smp, av, dv);
      e.st = 2'(m_st);
      e.start = (m_st == 3);
      e.lat = 32'(m_lat);
      @(posedge Mclk);
      sbq.push_back(e);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   always @(negedge Mclk) begin
      if (sbq.size() > 0) begin
         me = sbq.pop_front();
         vectors++;
         if (bus.State !== me.st || bus.Start !== me.start || bus.Trig_Lat !== me.lat) begin
            miscompares++;
            $display("FAIL sb_out t=%0t got st=%0d start=%0d lat=%0d want st=%0d start=%0d lat=%0d",
                     $time, bus.State, bus.Start, bus.Trig_Lat, me.st, me.start, me.lat);
         end
      end
   end

   task automatic dseg(input bit arm, input bit v, input int len);
      for (int i = 0; i < len; i++) step(0, arm && i == 0, 0, 1, '0, {v, 1'b0});
   endtask

   int aw[N_ACH];
   logic [N_ACH*DW-1:0] av;
   logic [N_DCH-1:0] dg;
   int ntrig, len, sdel, d;

   initial begin
      step(1, 0, 0, 0, '0, '0);
      step(1, 0, 0, 0, '0, '0);
      chk("reset_state", 32'(bus.State), 0);

      // Test 1: rising ramp, pos edge at Vth=128
      c_src = 0; c_type = 1; c_vth = 128; c_hold = 0;
      step(0, 1, 0, 1, '0, '0);
      for (int v = 0; v < 256; v++) begin
         step(0, 0, 0, 1, {8'd0, 8'(v)}, '0);
         if (v == 129) chk("t1_no_start_yet", 32'(bus.Start), 0);
         if (v == 130) begin
            chk("t1_start", 32'(bus.Start), 1);
            chk("t1_lat", bus.Trig_Lat, 130);
         end
      end

      // Test 2: saturated VH near top of range
      c_vth = 250;
      step(0, 1, 0, 1, {8'd0, 8'd255}, '0);
      for (int v = 255; v >= 0; v--) step(0, 0, 0, 1, {8'd0, 8'(v)}, '0);
      for (int v = 0; v < 256; v++) begin
         step(0, 0, 0, 1, {8'd0, 8'(v)}, '0);
         if (v == 251) chk("t2_no_start_yet", 32'(bus.Start), 0);
         if (v == 252) chk("t2_start", 32'(bus.Start), 1);
      end

      // Test 3: Dig1 low pulses, L>=T with T=10
      c_src = 3; c_type = 5; c_T = 10;
      dseg(1, 0, 5);
      dseg(0, 1, 8);
      dseg(0, 0, 5);
      dseg(0, 1, 8);
      chk("t3_short_pulse", 32'(bus.State), 2);
      dseg(0, 0, 20);
      dseg(0, 1, 5);
      chk("t3_long_pulse", 32'(bus.State), 3);

      // Test 4: holdoff and forced trigger from PRETRIG
      c_src = 0; c_type = 3; c_vth = 255; c_hold = 100;
      step(0, 1, 0, 0, '0, '0);
      for (int i = 1; i <= 50; i++) begin
         step(0, 0, i == 50, i >= 3, '0, '0);
         if (i == 49) chk("t4_pretrig", 32'(bus.State), 1);
         if (i == 50) chk("t4_force", 32'(bus.State), 3);
      end
      step(0, 1, 0, 1, '0, '0);
      for (int i = 1; i <= 101; i++) begin
         step(0, 0, 0, 1, '0, '0);
         if (i == 100) chk("t4_hold_pre", 32'(bus.State), 1);
         if (i == 101) chk("t4_hold_armed", 32'(bus.State), 2);
      end

      // Test 5: Arm beats a simultaneous condition
      c_vth = 100; c_hold = 0;
      step(0, 1, 0, 1, {8'd0, 8'd50}, '0);
      repeat (3) step(0, 0, 0, 1, {8'd0, 8'd50}, '0);
      step(0, 0, 0, 1, {8'd0, 8'd200}, '0);
      step(0, 1, 0, 1, {8'd0, 8'd50}, '0);
      chk("t5_state", 32'(bus.State), 1);
      chk("t5_start", 32'(bus.Start), 0);
      repeat (3) step(0, 0, 0, 1, {8'd0, 8'd50}, '0);

      // Test 6: reset from TRIG, then invalid source
      step(0, 0, 1, 1, {8'd0, 8'd50}, '0);
      chk("t6_trig", 32'(bus.State), 3);
      step(1, 0, 0, 1, {8'd0, 8'd50}, '0);
      chk("t6_reset_lat", bus.Trig_Lat, 0);
      c_src = 7;
      step(0, 1, 0, 1, '0, '0);
      ntrig = 0;
      for (int i = 0; i < 150; i++) begin
         c_type = $urandom_range(0, 7);
         step(0, 0, 0, 1, 16'($urandom), 2'($urandom));
         if (bus.State == 2'd3) ntrig++;
      end
      chk("t6_invalid_src", 32'(ntrig), 0);

      // Randomized scenarios
      dg = '0;
      for (int k = 0; k < N_ACH; k++) aw[k] = $urandom_range(0, 255);
      for (int s = 0; s < 25; s++) begin
         c_src = $urandom_range(0, 4);
         c_type = $urandom_range(0, 7);
         c_vth = $urandom_range(0, 255);
         c_T = $urandom_range(1, 12);
         c_hold = $urandom_range(0, 6);
         sdel = $urandom_range(0, 4);
         len = $urandom_range(60, 160);
         for (int t = 0; t < len; t++) begin
            for (int k = 0; k < N_ACH; k++) begin
               if ($urandom_range(0, 39) == 0) aw[k] = $urandom_range(0, 255);
               else begin
                  d = $urandom_range(0, 16);
                  aw[k] = aw[k] + d - 8;
                  if (aw[k] < 0) aw[k] = 0;
                  if (aw[k] > 255) aw[k] = 255;
               end
               av[k*DW +: DW] = 8'(aw[k]);
            end
            for (int k = 0; k < N_DCH; k++)
               if ($urandom_range(0, 5) == 0) dg[k] = ~dg[k];
            step($urandom_range(0, 299) == 0, (t == 0) || ($urandom_range(0, 79) == 0),
                 $urandom_range(0, 59) == 0, t >= sdel, av, dg);
         end
      end

      repeat (3) @(negedge Mclk);
      #2;
      chk("sb_drain", 32'(sbq.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
